// File: rtl/htif_serdes.sv
// htif_serdes: 64-bit host HTIF packets <-> narrow HTIF_WIDTH link, LSB beat first.
// Latency: TX first beat 1 cycle after wide accept; RX packet valid 1 cycle after last beat.
// Backpressure: valid/ready on all four sides; readies depend only on state and reset.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   wide_in_*               host packet in  (valid/ready/bits, WIDE_WIDTH)
//   htif_in_*               narrow beats to DUT (valid/ready/bits, HTIF_WIDTH)
//   htif_out_*              narrow beats from DUT (valid/ready/bits, HTIF_WIDTH)
//   wide_out_*              reassembled packet to host (valid/ready/bits, WIDE_WIDTH)
//   tx_count, rx_count      32-bit wrapping packet counters for debug
module htif_serdes #(
  parameter int HTIF_WIDTH = 16,
  parameter int WIDE_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wide_in_valid,
  output logic                  wide_in_ready,
  input  logic [WIDE_WIDTH-1:0] wide_in_bits,
  output logic                  htif_in_valid,
  input  logic                  htif_in_ready,
  output logic [HTIF_WIDTH-1:0] htif_in_bits,
  input  logic                  htif_out_valid,
  output logic                  htif_out_ready,
  input  logic [HTIF_WIDTH-1:0] htif_out_bits,
  output logic                  wide_out_valid,
  input  logic                  wide_out_ready,
  output logic [WIDE_WIDTH-1:0] wide_out_bits,
  output logic [31:0]           tx_count,
  output logic [31:0]           rx_count
);

  localparam int RATIO = WIDE_WIDTH / HTIF_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  // Explicit compare against the last index so non-power-of-2 ratios work.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (RATIO < 2 || RATIO * HTIF_WIDTH != WIDE_WIDTH) begin : g_param_check
    $error("htif_serdes: WIDE_WIDTH must be an integer multiple (>=2) of HTIF_WIDTH");
  end

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic {RX_FILL, RX_FULL} rx_state_t;

  tx_state_t             tx_state;
  rx_state_t             rx_state;
  logic [IDX_W-1:0]      tx_idx;
  logic [IDX_W-1:0]      rx_idx;
  logic [WIDE_WIDTH-1:0] tx_buf;
  logic [WIDE_WIDTH-1:0] rx_buf;
  logic [HTIF_WIDTH-1:0] tx_beat;

  // Serializer: tx_buf is only written from IDLE, so beats are stable in SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_idx   <= '0;
      tx_buf   <= '0;
      tx_count <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wide_in_valid) begin
            tx_buf   <= wide_in_bits;
            tx_idx   <= '0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (htif_in_ready) begin
            if (tx_idx == LAST_IDX) begin
              tx_idx   <= '0;
              tx_state <= TX_IDLE;
              tx_count <= tx_count + 32'd1;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Deserializer: a partial packet is simply abandoned by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_FILL;
      rx_idx   <= '0;
      rx_buf   <= '0;
      rx_count <= '0;
    end else begin
      case (rx_state)
        RX_FILL: begin
          if (htif_out_valid) begin
            for (int i = 0; i < RATIO; i++) begin
              if (rx_idx == IDX_W'(i)) rx_buf[i*HTIF_WIDTH +: HTIF_WIDTH] <= htif_out_bits;
            end
            if (rx_idx == LAST_IDX) begin
              rx_idx   <= '0;
              rx_state <= RX_FULL;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end
        end
        RX_FULL: begin
          if (wide_out_ready) begin
            rx_state <= RX_FILL;
            rx_count <= rx_count + 32'd1;
          end
        end
        default: rx_state <= RX_FILL;
      endcase
    end
  end

  // Beat mux with constant slice offsets.
  always_comb begin
    tx_beat = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (tx_idx == IDX_W'(i)) tx_beat = tx_buf[i*HTIF_WIDTH +: HTIF_WIDTH];
    end
  end

  // Reset gating keeps every handshake dead during reset, even in the
  // first reset cycle before the state registers have been cleared.
  assign wide_in_ready  = !reset && (tx_state == TX_IDLE);
  assign htif_in_valid  = !reset && (tx_state == TX_SEND);
  assign htif_in_bits   = htif_in_valid ? tx_beat : '0;
  assign htif_out_ready = !reset && (rx_state == RX_FILL);
  assign wide_out_valid = !reset && (rx_state == RX_FULL);
  assign wide_out_bits  = reset ? '0 : rx_buf;

endmodule
